// File: rtl/ad9122_spi_readback.sv
// AD9122 SPI register readback: sends a read instruction {1, addr[6:0]} and shifts in one data byte.
// Define AD9122_RB_3WIRE_EN for 3-wire readback on SDIO; otherwise data is taken from SDO (4-wire).
module ad9122_spi_readback #(
  parameter int SCLK_DIV = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AD9122_READ_EN,
  input  logic [6:0] AD9122_READ_ADDR,
  output logic       AD9122_READ_BUSY,
  output logic       AD9122_READ_DONE,
  output logic [7:0] READ_AD9122,
  output logic       AD9122_nCS,
  output logic       AD9122_SCLK,
  output logic       AD9122_SDIO,
  output logic       AD9122_SDIO_OE,
  input  logic       AD9122_SDIO_IN,
  input  logic       AD9122_SDO
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  logic rx_in;
  logic unused_pin;

`ifdef AD9122_RB_3WIRE_EN
  localparam logic DATA_OE = 1'b0;
  assign rx_in      = AD9122_SDIO_IN;
  assign unused_pin = AD9122_SDO;
`else
  localparam logic DATA_OE = 1'b1;
  assign rx_in      = AD9122_SDO;
  assign unused_pin = AD9122_SDIO_IN;
`endif

  state_t     state_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] sr_q, rx_q, rd_q;
  logic       ncs_q, sclk_q, sdio_q, oe_q, busy_q, done_q;

  assign cnt_d = cnt_q + 8'd1;
  assign bit_d = bit_q + 4'd1;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      sr_q    <= 8'd0;
      rx_q    <= 8'd0;
      rd_q    <= 8'd0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
      oe_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          ncs_q   <= 1'b1;
          sclk_q  <= 1'b0;
          sdio_q  <= 1'b0;
          oe_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (AD9122_READ_EN) begin
            sr_q    <= {1'b1, AD9122_READ_ADDR};
            cnt_q   <= 8'd0;
            ncs_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q >= SETUP_LAST) begin
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            sdio_q  <= sr_q[7];
            sr_q    <= {sr_q[6:0], 1'b0};
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        SHIFT: begin
          if (cnt_q >= DIV_LAST) begin
            cnt_q <= 8'd0;
            if (!sclk_q) begin
              // Rising phase: capture the device's data bit, MSB first
              sclk_q <= 1'b1;
              if (bit_q[3]) rx_q <= {rx_q[6:0], rx_in};
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == 4'd15) begin
                sdio_q  <= 1'b0;
                oe_q    <= 1'b1;
                state_q <= HOLD;
              end else begin
                bit_q <= bit_d;
                if (bit_d[3]) begin
                  sdio_q <= 1'b0;
                  oe_q   <= DATA_OE;
                end else begin
                  sdio_q <= sr_q[7];
                  sr_q   <= {sr_q[6:0], 1'b0};
                end
              end
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (cnt_q >= HOLD_LAST) begin
            cnt_q   <= 8'd0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rd_q    <= rx_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AD9122_READ_BUSY = busy_q;
  assign AD9122_READ_DONE = done_q;
  assign READ_AD9122      = rd_q;
  assign AD9122_nCS       = ncs_q;
  assign AD9122_SCLK      = sclk_q;
  assign AD9122_SDIO      = sdio_q;
  assign AD9122_SDIO_OE   = oe_q;

endmodule
